num_smul_pipe: RTL and testbench
================================

Name: num_smul_pipe

Overview:
- Parametrised successor to the two-cycle signed fixed-point multiplier.
- Adds configurable pipeline depth, selectable rounding of discarded fraction bits, optional saturation with an overflow flag, and a one-shot operand capture.
- Sits in the generated datapath as a Calyx-style go/done multiplier primitive used by fixed-point polynomial and convolution kernels.

Parameters:
- LEFT_WIDTH, 32: signed left operand width (>=2).
- RIGHT_WIDTH, 32: signed right operand width (>=2).
- OUT_WIDTH, 64: result width (>=2).
- OUT_LSB, 0: number of low product bits discarded before the result is formed (0 <= OUT_LSB < LEFT_WIDTH+RIGHT_WIDTH).
- STAGES, 1: product pipeline registers after operand capture (>=1). Latency = STAGES+1.
- ROUND, 0: rounding mode. 0 = truncate toward -inf; 1 = round-to-nearest-even.
- SATURATE, 0: overflow handling. 0 = wrap to OUT_WIDTH; 1 = clamp to the signed OUT_WIDTH range.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- left  in  LEFT_WIDTH  signed operand.
- right  in  RIGHT_WIDTH  signed operand.
- go  in  1  start. Held high by the controller until done is seen.
- out  out  OUT_WIDTH  signed result.
- overflow  out  1  high when the current out value was wrapped or clamped.
- done  out  1  result valid.

Behaviour:
- Reset (reset low, asynchronous): all state clears immediately.
  - out=0, overflow=0, done=0.
  - Capture flag and valid pipeline cleared.
- P = LEFT_WIDTH+RIGHT_WIDTH. The full signed product of width P is formed with no intermediate truncation.
- Capture: at the first rising edge where go=1 and the capture flag is 0:
  - left and right are registered;
  - the capture flag sets;
  - valid[0] is set.
  - While go stays high, the operands are not re-sampled. Later changes to left and right are ignored.
- Pipeline: valid and product advance one stage per edge through STAGES registers. The final stage applies rounding and overflow handling and registers out and overflow.
- Timing: done rises exactly STAGES+1 edges after the capture edge. With STAGES=1 it rises on the 2nd edge.
- done stays high for as long as go stays high. It is never asserted without a completed capture.
- go low at an edge:
  - capture flag and all valid bits clear; done goes low after that edge;
  - out and overflow hold their last values.
  - The next go starts a fresh capture.
- go dropped mid-flight: the in-flight result is discarded. out and overflow are not updated and done does not assert.
- Rounding (only when OUT_LSB>0 and ROUND=1):
  - guard = P[OUT_LSB-1]; sticky = OR of P[OUT_LSB-2:0]; lsb = P[OUT_LSB].
  - Add 1 to the kept field if guard & (sticky | lsb).
  - The kept field is sign-extended by 1 bit before the add so the carry is not lost.
- Overflow: the rounded value R is compared against the OUT_WIDTH signed range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Out of range and SATURATE=1: out is clamped to the nearest bound.
  - Out of range and SATURATE=0: out = R[OUT_WIDTH-1:0].
  - overflow=1 in both out-of-range cases.
  - If OUT_WIDTH covers the kept width plus 1 bit, R is sign-extended and overflow is constant 0.
- Reset mid-operation: pipeline flushed. No done until a new capture after reset is released.

Decomposition:
- Shared package num_pkg holds:
  - enum round_mode_t {NUM_ROUND_TRUNC, NUM_ROUND_RNE};
  - function num_latency(stages), which returns stages+1 for schedulers;
  - width-helper functions for kept-field width.
- Sub-module num_round_sat: combinational rounding, range check and clamp/wrap.
  - Parameters: IN_WIDTH, IN_LSB, OUT_WIDTH, ROUND, SATURATE.
  - It will be reused by the planned adder/divider successors.

Test Plan:
- LEFT=RIGHT=8, OUT_WIDTH=16, OUT_LSB=0, STAGES=1: left=3, right=-5, go held -> done on the 2nd edge, out=-15, overflow=0.
- STAGES=3, same widths: left=7, right=6 captured, then left=1, right=1 from the next cycle on -> done on exactly the 4th edge, out=42, done stays high while go is held.
- LEFT=RIGHT=8, OUT_WIDTH=8, OUT_LSB=4, products 24 / 40 / 56 (operands 3×8, 5×8, 7×8):
  - ROUND=1 -> out=2 / 2 / 4;
  - ROUND=0 -> out=1 / 2 / 3.
- LEFT=RIGHT=8, OUT_WIDTH=8, OUT_LSB=0, operands 100×100:
  - SATURATE=1 -> out=127, overflow=1;
  - SATURATE=0 -> out=16, overflow=1;
  - -128×127 with SATURATE=1 -> out=-128.
- Corner case, LEFT=RIGHT=8, OUT_WIDTH=15, SATURATE=1: -128×-128 -> out=16383, overflow=1. Same operands with OUT_WIDTH=16 -> out=16384, overflow=0.
- STAGES=3:
  - reset pulsed low one edge after capture -> out=0, done=0 immediately, no done until a new go;
  - separately, go dropped at the 2nd edge -> done never asserts and out keeps the previous result.

Source files
------------

// File: rtl/num_pkg.sv
// num_pkg
// Shared definitions for the fixed-point arithmetic primitives (multiplier
// today, adder/divider successors later).
//   round_mode_t     : rounding mode selector values for the ROUND parameter
//   num_latency      : go-to-done latency in edges for a given STAGES value
//   num_kept_width   : width of the field left after discarding low bits
//   num_round_width  : kept width plus one guard bit for the rounding carry
package num_pkg;

    typedef enum logic {
        NUM_ROUND_TRUNC = 1'b0,
        NUM_ROUND_RNE   = 1'b1
    } round_mode_t;

    // Edges from the capture edge (inclusive) to done for a pipeline with
    // 'stages' product registers: one capture edge plus one per stage.
    function automatic int num_latency(input int stages);
        return stages + 1;
    endfunction

    function automatic int num_kept_width(input int in_width, input int in_lsb);
        return in_width - in_lsb;
    endfunction

    // One extra bit so that rounding up the most positive kept value cannot
    // wrap before the range check sees it.
    function automatic int num_round_width(input int in_width, input int in_lsb);
        return num_kept_width(in_width, in_lsb) + 1;
    endfunction

endpackage

// File: rtl/num_round_sat.sv
// num_round_sat
// Combinational post-processing of a wide signed value: drop IN_LSB low bits
// (truncate toward -inf, or round-to-nearest-even), then fit the result into
// OUT_WIDTH bits by wrapping or clamping.
//   value    in  IN_WIDTH   signed input (two's complement)
//   result   out OUT_WIDTH  signed rounded and range-fitted result
//   overflow out 1          rounded value did not fit in OUT_WIDTH
module num_round_sat
    import num_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int IN_LSB    = 0,
    parameter int OUT_WIDTH = 64,
    parameter int ROUND     = 0,
    parameter int SATURATE  = 0
) (
    input  logic [IN_WIDTH-1:0]  value,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 overflow
);

    localparam int KEPT_W = num_kept_width(IN_WIDTH, IN_LSB);
    localparam int RND_W  = num_round_width(IN_WIDTH, IN_LSB);
    localparam bit DO_RNE = (IN_LSB > 0) && (ROUND == int'(NUM_ROUND_RNE));

    logic [KEPT_W-1:0] kept;
    logic              round_up;
    logic [RND_W-1:0]  rounded;

    // Dropping low bits of a two's complement value is already a floor.
    assign kept = value[IN_WIDTH-1:IN_LSB];

    generate
        if (DO_RNE) begin : g_rne
            logic guard;
            logic sticky;
            logic lsb;

            assign guard = value[IN_LSB-1];
            assign lsb   = value[IN_LSB];
            if (IN_LSB >= 2) begin : g_sticky
                assign sticky = |value[IN_LSB-2:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end
            // Above half, or exactly half with an odd kept value -> round up.
            assign round_up = guard & (sticky | lsb);
        end else begin : g_trunc
            assign round_up = 1'b0;
            if (IN_LSB > 0) begin : g_drop
                logic unused_low_bits;
                assign unused_low_bits = ^value[IN_LSB-1:0];
            end
        end
    endgenerate

    assign rounded = {kept[KEPT_W-1], kept} + {{KEPT_W{1'b0}}, round_up};

    generate
        if (OUT_WIDTH >= RND_W) begin : g_wide
            // Every rounded value fits: plain sign extension.
            assign result   = OUT_WIDTH'($signed(rounded));
            assign overflow = 1'b0;
        end else begin : g_narrow
            localparam int HI_W = RND_W - OUT_WIDTH + 1;

            logic [HI_W-1:0] hi_bits;
            logic            in_range;

            // In range exactly when all bits from the output sign bit upward
            // agree (pure sign extension).
            assign hi_bits  = rounded[RND_W-1:OUT_WIDTH-1];
            assign in_range = (&hi_bits) | ~(|hi_bits);
            assign overflow = ~in_range;

            if (SATURATE != 0) begin : g_sat
                always_comb begin
                    result = rounded[OUT_WIDTH-1:0];
                    if (!in_range) begin
                        if (rounded[RND_W-1]) begin
                            result = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                        end else begin
                            result = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                        end
                    end
                end
            end else begin : g_wrap
                assign result = rounded[OUT_WIDTH-1:0];
            end
        end
    endgenerate

endmodule

// File: rtl/num_smul_pipe.sv
// num_smul_pipe
// Pipelined signed fixed-point multiplier with a go/done handshake.
// Operands are captured once per go assertion; the full product passes
// through STAGES registers, the last of which rounds, range-fits and
// registers the result. done rises STAGES+1 edges after go is first seen.
//   clk      in  1            clock, rising edge
//   reset    in  1            asynchronous active-low reset
//   left     in  LEFT_WIDTH   signed operand
//   right    in  RIGHT_WIDTH  signed operand
//   go       in  1            start; held high until done is seen
//   out      out OUT_WIDTH    signed result
//   overflow out 1            out was wrapped or clamped
//   done     out 1            out is valid for the current go
module num_smul_pipe
    import num_pkg::*;
#(
    parameter int LEFT_WIDTH  = 32,
    parameter int RIGHT_WIDTH = 32,
    parameter int OUT_WIDTH   = 64,
    parameter int OUT_LSB     = 0,
    parameter int STAGES      = 1,
    parameter int ROUND       = 0,
    parameter int SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEFT_WIDTH-1:0]  left,
    input  logic [RIGHT_WIDTH-1:0] right,
    input  logic                   go,
    output logic [OUT_WIDTH-1:0]   out,
    output logic                   overflow,
    output logic                   done
);

    localparam int PROD_W    = LEFT_WIDTH + RIGHT_WIDTH;
    localparam int VALID_LEN = num_latency(STAGES);

    logic [LEFT_WIDTH-1:0]  left_reg;
    logic [RIGHT_WIDTH-1:0] right_reg;
    // valid_reg[0] doubles as the capture flag: it is set on the capture
    // edge and stays set until go drops, which blocks re-sampling.
    logic [VALID_LEN-1:0]   valid_reg;

    logic [PROD_W-1:0]      left_ext;
    logic [PROD_W-1:0]      right_ext;
    logic [PROD_W-1:0]      prod_comb;
    logic [PROD_W-1:0]      prod_lvl [STAGES];

    logic [OUT_WIDTH-1:0]   rs_result;
    logic                   rs_overflow;

    // Sign-extend both operands to the full product width; the low PROD_W
    // bits of an unsigned multiply are then the exact signed product.
    assign left_ext  = {{RIGHT_WIDTH{left_reg[LEFT_WIDTH-1]}}, left_reg};
    assign right_ext = {{LEFT_WIDTH{right_reg[RIGHT_WIDTH-1]}}, right_reg};
    assign prod_comb = left_ext * right_ext;

    // Level 0 is the combinational product of the captured operands; each
    // further level is one register. The final output register is the last
    // stage, so STAGES-1 product registers sit in front of it.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign prod_lvl[gi] = prod_comb;
            end else begin : g_reg
                logic [PROD_W-1:0] prod_reg;

                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        prod_reg <= '0;
                    end else begin
                        prod_reg <= prod_lvl[gi-1];
                    end
                end

                assign prod_lvl[gi] = prod_reg;
            end
        end
    endgenerate

    num_round_sat #(
        .IN_WIDTH  (PROD_W),
        .IN_LSB    (OUT_LSB),
        .OUT_WIDTH (OUT_WIDTH),
        .ROUND     (ROUND),
        .SATURATE  (SATURATE)
    ) u_round_sat (
        .value    (prod_lvl[STAGES-1]),
        .result   (rs_result),
        .overflow (rs_overflow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_reg  <= '0;
            right_reg <= '0;
            valid_reg <= '0;
            out       <= '0;
            overflow  <= 1'b0;
        end else if (!go) begin
            // Abandon any capture and in-flight result; out/overflow hold.
            valid_reg <= '0;
        end else begin
            if (!valid_reg[0]) begin
                left_reg  <= left;
                right_reg <= right;
            end
            valid_reg <= {valid_reg[VALID_LEN-2:0], 1'b1};
            if (valid_reg[VALID_LEN-2]) begin
                out      <= rs_result;
                overflow <= rs_overflow;
            end
        end
    end

    assign done = valid_reg[VALID_LEN-1];

endmodule

// File: tb/tb_num_smul_pipe.sv
module tb_num_smul_pipe;

    localparam int NCFG = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] left;
    logic signed [7:0] right;
    logic              go;

    logic signed [63:0] out_ext [NCFG];
    logic               ovf     [NCFG];
    logic               dn      [NCFG];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Configurations: 0 basic, 1 three stages, 2 RNE, 3 truncate,
    // 4 saturate, 5 wrap, 6 15-bit saturate, 7 RNE+saturate two stages.
    function automatic int cfg_w(input int i);
        case (i)
            0, 1:    return 16;
            6:       return 15;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_lsb(input int i);
        return (i == 2 || i == 3 || i == 7) ? 4 : 0;
    endfunction

    function automatic int cfg_st(input int i);
        return (i == 1) ? 3 : ((i == 7) ? 2 : 1);
    endfunction

    function automatic int cfg_rnd(input int i);
        return (i == 2 || i == 7) ? 1 : 0;
    endfunction

    function automatic int cfg_sat(input int i);
        return (i == 4 || i == 6 || i == 7) ? 1 : 0;
    endfunction

    generate
        for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
            logic [cfg_w(gi)-1:0] o;
            logic                 ov_i;
            logic                 dn_i;

            num_smul_pipe #(
                .LEFT_WIDTH  (8),
                .RIGHT_WIDTH (8),
                .OUT_WIDTH   (cfg_w(gi)),
                .OUT_LSB     (cfg_lsb(gi)),
                .STAGES      (cfg_st(gi)),
                .ROUND       (cfg_rnd(gi)),
                .SATURATE    (cfg_sat(gi))
            ) u_dut (
                .clk      (clk),
                .reset    (reset),
                .left     (left),
                .right    (right),
                .go       (go),
                .out      (o),
                .overflow (ov_i),
                .done     (dn_i)
            );

            assign out_ext[gi] = 64'($signed(o));
            assign ovf[gi]     = ov_i;
            assign dn[gi]      = dn_i;
        end
    endgenerate

    // Reference: exact product, scaled by 2^-lsb with floor or
    // round-half-to-even, then clamped or reduced modulo 2^w.
    function automatic longint model(input int l, input int r, input int i,
                                     output bit ov);
        longint p, q, rem, half, maxv, minv, span;
        int     w;
        int     lsb;
        w    = cfg_w(i);
        lsb  = cfg_lsb(i);
        p    = longint'(l) * longint'(r);
        q    = p >>> lsb;
        if (cfg_rnd(i) != 0 && lsb > 0) begin
            rem  = p - q * (longint'(1) << lsb);
            half = longint'(1) << (lsb - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        span = longint'(1) << w;
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -maxv - 1;
        ov   = (q > maxv) || (q < minv);
        if (ov) begin
            if (cfg_sat(i) != 0) begin
                q = (q > maxv) ? maxv : minv;
            end else begin
                q = q & (span - 1);
                if (q > maxv) q = q - span;
            end
        end
        return q;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int     cfg;
        int     l;
        int     r;
        longint exp_out;
        bit     exp_ov;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   l, r;
        bit   mov;
        longint mout;

        vecs.push_back('{0,    3,   -5,   -15, 1'b0});
        vecs.push_back('{2,    3,    8,     2, 1'b0});
        vecs.push_back('{2,    5,    8,     2, 1'b0});
        vecs.push_back('{2,    7,    8,     4, 1'b0});
        vecs.push_back('{2,   -3,    8,    -2, 1'b0});
        vecs.push_back('{2,   -5,    8,    -2, 1'b0});
        vecs.push_back('{3,    3,    8,     1, 1'b0});
        vecs.push_back('{3,    5,    8,     2, 1'b0});
        vecs.push_back('{3,    7,    8,     3, 1'b0});
        vecs.push_back('{3,   -3,    8,    -2, 1'b0});
        vecs.push_back('{3,   -5,    8,    -3, 1'b0});
        vecs.push_back('{4,  100,  100,   127, 1'b1});
        vecs.push_back('{4, -128,  127,  -128, 1'b1});
        vecs.push_back('{5,  100,  100,    16, 1'b1});
        vecs.push_back('{5, -128,  127,  -128, 1'b1});
        vecs.push_back('{6, -128, -128, 16383, 1'b1});
        vecs.push_back('{0, -128, -128, 16384, 1'b0});
        vecs.push_back('{7,  127,  127,   127, 1'b1});

        // Reset state
        reset = 1'b0;
        go    = 1'b0;
        left  = '0;
        right = '0;
        tick(2);
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("reset cfg%0d out", i), out_ext[i], 0);
            chk($sformatf("reset cfg%0d ovf", i), {63'b0, ovf[i]}, 0);
            chk($sformatf("reset cfg%0d done", i), {63'b0, dn[i]}, 0);
        end
        reset = 1'b1;
        tick(1);

        // Table vectors
        foreach (vecs[k]) begin
            left  = 8'(vecs[k].l);
            right = 8'(vecs[k].r);
            go    = 1'b1;
            tick(6);
            chk($sformatf("vec%0d cfg%0d out", k, vecs[k].cfg), out_ext[vecs[k].cfg], vecs[k].exp_out);
            chk($sformatf("vec%0d cfg%0d ovf", k, vecs[k].cfg), {63'b0, ovf[vecs[k].cfg]}, {63'b0, vecs[k].exp_ov});
            chk($sformatf("vec%0d cfg%0d done", k, vecs[k].cfg), {63'b0, dn[vecs[k].cfg]}, 1);
            go = 1'b0;
            tick(1);
            chk($sformatf("vec%0d cfg%0d done_low", k, vecs[k].cfg), {63'b0, dn[vecs[k].cfg]}, 0);
        end

        // Latency: 7x6 captured, operands then change to 1x1
        left  = 8'sd7;
        right = 8'sd6;
        go    = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            if (e == 1) begin
                left  = 8'sd1;
                right = 8'sd1;
            end
            chk($sformatf("lat edge%0d s1 done", e), {63'b0, dn[0]}, (e >= 2) ? 1 : 0);
            chk($sformatf("lat edge%0d s3 done", e), {63'b0, dn[1]}, (e >= 4) ? 1 : 0);
            if (e >= 2) chk($sformatf("lat edge%0d s1 out", e), out_ext[0], 42);
            if (e >= 4) chk($sformatf("lat edge%0d s3 out", e), out_ext[1], 42);
        end
        go = 1'b0;
        tick(1);

        // go dropped at the 2nd edge: no done, previous result kept
        left  = 8'sd3;
        right = 8'sd3;
        go    = 1'b1;
        tick(1);
        go = 1'b0;
        for (int e = 2; e <= 7; e++) begin
            tick(1);
            chk($sformatf("drop edge%0d done", e), {63'b0, dn[1]}, 0);
            chk($sformatf("drop edge%0d out", e), out_ext[1], 42);
        end
        go = 1'b1;
        tick(3);
        chk("restart edge3 done", {63'b0, dn[1]}, 0);
        tick(1);
        chk("restart edge4 done", {63'b0, dn[1]}, 1);
        chk("restart edge4 out", out_ext[1], 9);
        go = 1'b0;
        tick(1);

        // Reset one edge after capture
        left  = 8'sd5;
        right = 8'sd5;
        go    = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        chk("midreset s3 out", out_ext[1], 0);
        chk("midreset s3 done", {63'b0, dn[1]}, 0);
        chk("midreset s1 out", out_ext[0], 0);
        go = 1'b0;
        tick(1);
        reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            chk($sformatf("postreset edge%0d done", e), {63'b0, dn[1]}, 0);
        end
        go = 1'b1;
        tick(3);
        chk("newgo edge3 done", {63'b0, dn[1]}, 0);
        tick(1);
        chk("newgo edge4 done", {63'b0, dn[1]}, 1);
        chk("newgo edge4 out", out_ext[1], 25);
        go = 1'b0;
        tick(1);

        // Randomized operands against the reference model
        for (int k = 0; k < 150; k++) begin
            l     = int'($urandom_range(0, 255)) - 128;
            r     = int'($urandom_range(0, 255)) - 128;
            left  = 8'(l);
            right = 8'(r);
            go    = 1'b1;
            tick(1);
            left  = 8'($urandom_range(0, 255));
            right = 8'($urandom_range(0, 255));
            tick(4);
            for (int i = 0; i < NCFG; i++) begin
                mout = model(l, r, i, mov);
                chk($sformatf("rand%0d %0dx%0d cfg%0d out", k, l, r, i), out_ext[i], mout);
                chk($sformatf("rand%0d %0dx%0d cfg%0d ovf", k, l, r, i), {63'b0, ovf[i]}, {63'b0, mov});
                chk($sformatf("rand%0d cfg%0d done", k, i), {63'b0, dn[i]}, 1);
            end
            go = 1'b0;
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
